divider_nx4_seq: RTL and testbench



---
 rtl/divider_nx4_seq.sv | 182 ++++++++++++++++++
 tb/tb_divider_nx4_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_nx4_seq.sv
// -----------------------------------------------------------------------------
// divider_nx4_seq
// Sequential restoring divider: N-bit dividend A / 4-bit divisor B, producing
// an N-bit quotient Q and 4-bit remainder R at one quotient bit per clock.
// A zero divisor takes a one-cycle side path that reports dbz with Q = all ones.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous active-high reset
//   start  in   1  request a division (honoured only when busy = 0)
//   A      in   N  dividend, captured on the accepting edge
//   B      in   4  divisor, captured on the accepting edge
//   Q      out  N  quotient, registered, held until the next result
//   R      out  4  remainder, registered, held until the next result
//   busy   out  1  operation in progress
//   done   out  1  one-cycle pulse: Q, R and dbz are valid
//   dbz    out  1  divide-by-zero flag, valid with done
// -----------------------------------------------------------------------------
module divider_nx4_seq #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [3:0]   B,
  output logic [N-1:0] Q,
  output logic [3:0]   R,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
  logic [N-1:0]   r_sr;
  logic [3:0]     r_div;
  logic [3:0]     r_rem;
  logic [CW-1:0]  r_cnt;

  logic [N-1:0]   r_q;
  logic [3:0]     r_r;
  logic           r_busy;
  logic           r_done;
  logic           r_dbz;

  logic           w_load;
  logic           w_zero_go;
  logic           w_step;
  logic           w_finish;
  logic           w_zero_done;

  logic [4:0]     w_shifted;
  logic [4:0]     w_trial;
  logic           w_qbit;
  logic [3:0]     w_rem_nxt;
  logic [N-1:0]   w_sr_nxt;

  // One restoring step. The remainder is always below the divisor, so only the
  // trial subtraction needs a 5th bit (its sign); the stored remainder is 4 bits.
  assign w_shifted = {r_rem, r_sr[N-1]};
  assign w_trial   = w_shifted - {1'b0, r_div};
  assign w_qbit    = ~w_trial[4];
  assign w_rem_nxt = w_qbit ? w_trial[3:0] : w_shifted[3:0];
  assign w_sr_nxt  = {r_sr[N-2:0], w_qbit};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_zero_go   = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_zero_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (B != 4'd0) begin
            w_load      = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_zero_go   = 1'b1;
            w_state_nxt = S_ZERO;
          end
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ZERO: begin
        w_zero_done = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr   <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_load) begin
        r_sr   <= A;
        r_div  <= B;
        r_rem  <= '0;
        r_cnt  <= CW'(N);
        r_busy <= 1'b1;
      end

      // Zero divisor: nothing is captured, only busy is raised for one cycle.
      if (w_zero_go) begin
        r_busy <= 1'b1;
      end

      if (w_step) begin
        r_sr  <= w_sr_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt - CW'(1);
      end

      // Last iteration: publish the step's results directly.
      if (w_finish) begin
        r_q    <= w_sr_nxt;
        r_r    <= w_rem_nxt;
        r_dbz  <= 1'b0;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end

      if (w_zero_done) begin
        r_q    <= '1;
        r_r    <= '0;
        r_dbz  <= 1'b1;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign busy = r_busy;
  assign done = r_done;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_divider_nx4_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_nx4_seq
// Directed bench for divider_nx4_seq with an N=4 and an N=8 instance.
// Expected results are computed from A and B when a request is driven, queued,
// and compared when done is seen.
// -----------------------------------------------------------------------------
module tb_divider_nx4_seq;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       s4_start;
  logic [3:0] s4_A, s4_B;
  logic [3:0] q4, r4;
  logic       busy4, done4, dbz4;

  logic       s8_start;
  logic [7:0] s8_A;
  logic [3:0] s8_B;
  logic [7:0] q8;
  logic [3:0] r8;
  logic       busy8, done8, dbz8;

  divider_nx4_seq #(.N(4)) u_div4 (
    .clk(clk), .rst(rst), .start(s4_start), .A(s4_A), .B(s4_B),
    .Q(q4), .R(r4), .busy(busy4), .done(done4), .dbz(dbz4)
  );

  divider_nx4_seq #(.N(8)) u_div8 (
    .clk(clk), .rst(rst), .start(s8_start), .A(s8_A), .B(s8_B),
    .Q(q8), .R(r8), .busy(busy8), .done(done8), .dbz(dbz8)
  );

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_done4  = 0;
  int n_done8  = 0;
  int cur      = 0;

  // Pulse counters (cycles with done high).
  always @(negedge clk) begin
    if (done4 === 1'b1) n_done4++;
    if (done8 === 1'b1) n_done8++;
  end

  // View of whichever instance is currently under test.
  wire [7:0] m_q    = (cur == 1) ? q8    : {4'b0000, q4};
  wire [3:0] m_r    = (cur == 1) ? r8    : r4;
  wire       m_busy = (cur == 1) ? busy8 : busy4;
  wire       m_done = (cur == 1) ? done8 : done4;
  wire       m_dbz  = (cur == 1) ? dbz8  : dbz4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one request for a cycle (call at a negedge); pushes the expected result.
  task automatic start_op(input int sel, input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    cur = sel;
    if (b == 4'd0) begin
      e.q   = (sel == 1) ? 8'hFF : 8'h0F;
      e.r   = 4'd0;
      e.dbz = 1'b1;
    end else begin
      e.q   = 8'(int'(a) / int'(b));
      e.r   = 4'(int'(a) % int'(b));
      e.dbz = 1'b0;
    end
    sb.push_back(e);
    if (sel == 1) begin
      s8_A = a; s8_B = b; s8_start = 1'b1;
    end else begin
      s4_A = a[3:0]; s4_B = b; s4_start = 1'b1;
    end
    @(negedge clk);
    s4_start = 1'b0;
    s8_start = 1'b0;
  endtask

  // Wait (bounded) for done; checks busy while waiting, latency, and result.
  task automatic wait_done(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (m_done !== 1'b1 && lat < 40) begin
      chk({tag, "_busy_run"}, 32'(m_busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done"}, 32'(m_done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_with_done"}, 32'(m_busy), 32'd0);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, 32'(m_q), 32'(e.q));
      chk({tag, "_r"}, 32'(m_r), 32'(e.r));
      chk({tag, "_dbz"}, 32'(m_dbz), 32'(e.dbz));
    end
  endtask

  initial begin
    int         d0;
    logic [7:0] a;

    rst = 1'b1;
    s4_start = 1'b0; s4_A = '0; s4_B = '0;
    s8_start = 1'b0; s8_A = '0; s8_B = '0;
    repeat (2) @(negedge clk);

    // Reset state of both instances.
    chk("rst4_q", 32'(q4), 32'd0);     chk("rst4_r", 32'(r4), 32'd0);
    chk("rst4_busy", 32'(busy4), 32'd0); chk("rst4_done", 32'(done4), 32'd0);
    chk("rst4_dbz", 32'(dbz4), 32'd0);
    chk("rst8_q", 32'(q8), 32'd0);     chk("rst8_r", 32'(r8), 32'd0);
    chk("rst8_busy", 32'(busy8), 32'd0); chk("rst8_done", 32'(done8), 32'd0);
    chk("rst8_dbz", 32'(dbz8), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 13 / 3
    start_op(0, 8'd13, 4'd3);
    wait_done("t1", 4);
    chk("t1_q_lit", 32'(q4), 32'd4);
    chk("t1_r_lit", 32'(r4), 32'd1);

    // 15 / 1, then 2 / 9 issued in the done cycle
    @(negedge clk);
    start_op(0, 8'd15, 4'd1);
    wait_done("t2a", 4);
    start_op(0, 8'd2, 4'd9);
    wait_done("t2b", 4);
    chk("t2b_q_lit", 32'(q4), 32'd0);
    chk("t2b_r_lit", 32'(r4), 32'd2);

    // Divide by zero, then a normal divide clears dbz
    start_op(0, 8'd7, 4'd0);
    wait_done("t3a", 1);
    chk("t3a_q_lit", 32'(q4), 32'd15);
    start_op(0, 8'd6, 4'd2);
    wait_done("t3b", 4);
    chk("t3b_dbz_lit", 32'(dbz4), 32'd0);

    // Second start during RUN is ignored
    @(negedge clk);
    #1;
    d0 = n_done4;
    start_op(0, 8'd9, 4'd4);
    s4_A = 4'd1; s4_B = 4'd1; s4_start = 1'b1;
    @(negedge clk);
    s4_start = 1'b0;
    wait_done("t4", 3);
    chk("t4_q_lit", 32'(q4), 32'd2);
    chk("t4_r_lit", 32'(r4), 32'd1);
    repeat (6) @(negedge clk);
    #1;
    chk("t4_done_pulses", 32'(n_done4 - d0), 32'd1);
    chk("t4_idle_after", 32'(busy4), 32'd0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start_op(0, 8'd14, 4'd5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_q", 32'(q4), 32'd0);
    chk("t5_rst_r", 32'(r4), 32'd0);
    chk("t5_rst_busy", 32'(busy4), 32'd0);
    chk("t5_rst_done", 32'(done4), 32'd0);
    chk("t5_rst_dbz", 32'(dbz4), 32'd0);
    sb.delete();
    d0 = n_done4;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_no_done_after_abort", 32'(n_done4 - d0), 32'd0);
    @(negedge clk);
    start_op(0, 8'd14, 4'd5);
    wait_done("t5", 4);
    chk("t5_q_lit", 32'(q4), 32'd2);
    chk("t5_r_lit", 32'(r4), 32'd4);

    // N=8: 200 / 7
    @(negedge clk);
    start_op(1, 8'd200, 4'd7);
    wait_done("t6", 8);
    chk("t6_q_lit", 32'(q8), 32'd28);
    chk("t6_r_lit", 32'(r8), 32'd4);

    // N=8 sweep over every divisor, back-to-back requests
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      a = 8'd0;
        else if (k == 1) a = 8'd255;
        else             a = 8'($urandom_range(255, 0));
        start_op(1, a, 4'(b));
        wait_done("sweep", (b == 0) ? 1 : 8);
        if (b != 0) begin
          chk("sweep_reconstruct", 32'(int'(q8) * b + int'(r8)), 32'(a));
          chk("sweep_r_lt_b", 32'(int'(r8) < b), 32'd1);
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
